// File: rtl/saradc_pkg.sv
// rtl/saradc_pkg.sv - register map, bit indices and FSM state encoding for the SAR ADC reader
// Contents:
//   REG_*      word offsets decoded from wbs_adr_i[3:2]
//   CTRL_*     CTRL register bit positions
//   STAT_*     STATUS register bit positions
//   state_e    sequencer states, encoding visible in STATUS[14:12]
package saradc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CAL    = 1;
  localparam int CTRL_SINGLE = 2;
  localparam int CTRL_FLUSH  = 3;

  localparam int STAT_EMPTY     = 8;
  localparam int STAT_FULL      = 9;
  localparam int STAT_OVF       = 10;
  localparam int STAT_TMO       = 11;
  localparam int STAT_STATE_LSB = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CAL  = 3'd1,
    S_CONV = 3'd2
  } state_e;

endpackage

// File: rtl/saradc_sample_reader_if.sv
// rtl/saradc_sample_reader_if.sv - Wishbone slave and saradc macro signal bundle
// Signals:
//   wbs_*          Wishbone slave port (cyc/stb/we/sel/adr/dat_i in, ack/dat_o out)
//   adc_cal_o/en_o sequencing outputs to the saradc macro
//   adc_valid_i    saradc valid level, rising edge marks a new result
//   adc_result_i   saradc conversion result
//   irq_o          interrupt level
// Modports: slave = reader block view, master = bus/ADC side view.
interface saradc_sample_reader_if #(
  parameter int RES_W = 10
);
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic             wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic             adc_cal_o;
  logic             adc_en_o;
  logic             adc_valid_i;
  logic [RES_W-1:0] adc_result_i;
  logic             irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  adc_valid_i, adc_result_i,
    output wbs_ack_o, wbs_dat_o, adc_cal_o, adc_en_o, irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output adc_valid_i, adc_result_i,
    input  wbs_ack_o, wbs_dat_o, adc_cal_o, adc_en_o, irq_o
  );

endinterface

// File: rtl/saradc_sample_fifo.sv
// rtl/saradc_sample_fifo.sv - sample FIFO with push/pop/flush and occupancy count
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and data; dropped when full unless popped same clock
//   pop, dout  read request and head entry (dout valid while not empty)
//   flush      empties the FIFO; beats a same-clock push
//   count      occupancy, 0..DEPTH
//   full/empty occupancy flags
module saradc_sample_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  // A pop frees the slot the push lands in, so push is allowed when full
  // as long as a pop happens in the same clock.
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~flush & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/saradc_sample_reader.sv
// rtl/saradc_sample_reader.sv - SAR ADC sequencer, sample capture FIFO and Wishbone register block
// Ports:
//   wb_clk_i  clock shared with the ADC
//   wb_rst_i  asynchronous active-high reset
//   bus       slave view of saradc_sample_reader_if (Wishbone slave, saradc cal/en/valid/result, irq_o)
module saradc_sample_reader
  import saradc_pkg::*;
#(
  parameter int RES_W      = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int CAL_CYCLES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  saradc_sample_reader_if.slave bus
);

  localparam int FCW  = $clog2(FIFO_DEPTH + 1);
  localparam int MAXC = (TIMEOUT > CAL_CYCLES) ? TIMEOUT : CAL_CYCLES;
  localparam int TCW  = $clog2(MAXC + 1);
  localparam logic [TCW-1:0] CAL_LAST = TCW'(CAL_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [TCW-1:0] cnt_q, cnt_d;
  logic           run_q, run_d;
  logic           single_q, single_d;
  logic           ovf_q, ovf_d;
  logic           tmo_q, tmo_d;
  logic           cal_q, cal_d;
  logic           en_q, en_d;
  logic           ack_q, ack_d;
  logic           irq_q, irq_d;
  logic           vld_q, vld_d;
  logic [7:0]     thresh_q, thresh_d;
  logic [31:0]    dat_q, dat_d;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [RES_W-1:0] fifo_dout;
  logic [FCW-1:0]   fifo_count;
  logic [7:0]       count8;

  logic       acc, wr, rd, vld_edge;
  logic [1:0] reg_sel;
  logic       ctrl_wr, stat_wr, thr_wr;
  logic       cal_req, conv_req;
  logic [31:0] rd_data, stat_word;
  logic       unused_bits;

  // A new access is only recognised while ack is low, which spaces acks apart
  // and makes every side effect fire exactly once, on the edge that raises ack.
  assign acc      = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign wr       = acc & bus.wbs_we_i & bus.wbs_sel_i[0];
  assign rd       = acc & ~bus.wbs_we_i;
  assign reg_sel  = bus.wbs_adr_i[3:2];
  assign ctrl_wr  = wr && (reg_sel == REG_CTRL);
  assign stat_wr  = wr && (reg_sel == REG_STATUS);
  assign thr_wr   = wr && (reg_sel == REG_THRESH);
  assign cal_req  = ctrl_wr & bus.wbs_dat_i[CTRL_CAL];
  assign conv_req = ctrl_wr & (bus.wbs_dat_i[CTRL_RUN] | bus.wbs_dat_i[CTRL_SINGLE]);

  assign fifo_flush = ctrl_wr & bus.wbs_dat_i[CTRL_FLUSH];
  assign fifo_pop   = rd && (reg_sel == REG_DATA) && !fifo_empty;
  assign vld_edge   = bus.adc_valid_i & ~vld_q;
  assign vld_d      = bus.adc_valid_i;
  assign count8     = 8'(fifo_count);

  assign unused_bits = ^{bus.wbs_sel_i[3:1], bus.wbs_adr_i[31:4], bus.wbs_adr_i[1:0],
                         bus.wbs_dat_i[31:12], bus.wbs_dat_i[9:8]};

  saradc_sample_fifo #(
    .W     (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (bus.adc_result_i),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    stat_word = 32'(count8);
    stat_word[STAT_EMPTY] = fifo_empty;
    stat_word[STAT_FULL]  = fifo_full;
    stat_word[STAT_OVF]   = ovf_q;
    stat_word[STAT_TMO]   = tmo_q;
    stat_word[STAT_STATE_LSB +: 3] = state_q;

    rd_data = '0;
    case (reg_sel)
      REG_CTRL:   rd_data = 32'(run_q);
      REG_STATUS: rd_data = stat_word;
      REG_DATA:   rd_data = fifo_empty ? 32'h0 : (32'h8000_0000 | 32'(fifo_dout));
      default:    rd_data = 32'(thresh_q);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    single_d  = single_q;
    cal_d     = cal_q;
    en_d      = en_q;
    thresh_d  = thresh_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    fifo_push = 1'b0;

    ack_d = acc;
    dat_d = rd ? rd_data : 32'h0;

    if (ctrl_wr) run_d = bus.wbs_dat_i[CTRL_RUN];
    if (thr_wr)  thresh_d = bus.wbs_dat_i[7:0];
    if (stat_wr && bus.wbs_dat_i[STAT_OVF]) ovf_d = 1'b0;
    if (stat_wr && bus.wbs_dat_i[STAT_TMO]) tmo_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Entry is triggered by the write itself, not the RUN level, so a
        // timeout leaves the block parked in IDLE until software restarts it.
        if (cal_req) begin
          state_d = S_CAL;
          cal_d   = 1'b1;
          cnt_d   = '0;
        end else if (conv_req) begin
          state_d  = S_CONV;
          en_d     = 1'b1;
          cnt_d    = '0;
          single_d = ~bus.wbs_dat_i[CTRL_RUN];
        end
      end
      S_CAL: begin
        if (cnt_q == CAL_LAST) begin
          state_d = S_IDLE;
          cal_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + TCW'(1);
        end
      end
      S_CONV: begin
        if (!run_q && !single_q) begin
          // RUN was cleared: leave now and drop any sample arriving this clock.
          state_d = S_IDLE;
          en_d    = 1'b0;
        end else if (vld_edge) begin
          fifo_push = 1'b1;
          cnt_d     = '0;
          if (!run_q) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
          end
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + TCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cal_d   = 1'b0;
        en_d    = 1'b0;
      end
    endcase

    // Overflow is a push the FIFO had to drop; a pop frees room and a flush
    // discards the push outright, so neither case counts.
    if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) ovf_d = 1'b1;

    irq_d = ((count8 >= thresh_q) && (thresh_q != 8'd0)) | ovf_q | tmo_q;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      single_q <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cal_q    <= 1'b0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      vld_q    <= 1'b0;
      thresh_q <= 8'd1;
      dat_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      single_q <= single_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
      cal_q    <= cal_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
      vld_q    <= vld_d;
      thresh_q <= thresh_d;
      dat_q    <= dat_d;
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign bus.adc_cal_o = cal_q;
  assign bus.adc_en_o  = en_q;
  assign bus.irq_o     = irq_q;

endmodule

// File: tb/tb_saradc_sample_reader.sv
// tb/tb_saradc_sample_reader.sv - self-checking bench for saradc_sample_reader
module tb_saradc_sample_reader;

  localparam int RES_W = 10;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  saradc_sample_reader_if #(.RES_W(RES_W)) bus ();

  saradc_sample_reader #(
    .RES_W      (RES_W),
    .FIFO_DEPTH (DEPTH),
    .CAL_CYCLES (16),
    .TIMEOUT    (1024)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] rd;
  logic [31:0] exp;

  function automatic logic [31:0] exp_status(input int cnt, input bit ovf, input bit tmo,
                                             input logic [2:0] st);
    logic [31:0] v;
    v = 32'(cnt);
    v[8] = (cnt == 0);
    v[9] = (cnt == DEPTH);
    v[10] = ovf;
    v[11] = tmo;
    v[14:12] = st;
    return v;
  endfunction

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] q);
    int n;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = w;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = a;
    bus.wbs_dat_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 8);
    if (bus.wbs_ack_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wb_ack_timeout adr=%h ack=%b expected=1", a, bus.wbs_ack_o);
    end
    q = bus.wbs_dat_o;
    bus_idle();
  endtask

  task automatic adc_pulse(input logic [RES_W-1:0] r, input bit expect_push);
    @(negedge clk);
    bus.adc_valid_i  = 1'b1;
    bus.adc_result_i = r;
    @(negedge clk);
    bus.adc_valid_i = 1'b0;
    if (expect_push) begin
      if (m_cnt < DEPTH) begin
        exp_q.push_back({1'b1, 21'b0, r});
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.wbs_ack_o, bus.adc_cal_o, bus.adc_en_o, bus.irq_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b expected=0000",
               {bus.wbs_ack_o, bus.adc_cal_o, bus.adc_en_o, bus.irq_o});
    end
    n_cmp++;
    if (bus.wbs_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_dat got=%h expected=0", bus.wbs_dat_o);
    end
    rst = 1'b0;
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL reset_status got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd0));
    end
    wb_access(1'b0, 32'hC, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_bad++;
      $display("FAIL reset_thresh got=%h expected=1", rd);
    end
    wb_access(1'b0, 32'h0, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%h expected=0", rd);
    end
    wb_access(1'b0, 32'h8, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data_empty got=%h expected=0", rd);
    end
  endtask

  task automatic test_cal();
    int n;
    wb_access(1'b1, 32'h0, 32'h2, rd);
    n = 0;
    while (bus.adc_cal_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL cal_length got=%0d expected=16", n);
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL cal_done_status got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd0));
    end
    // CAL together with SINGLE: calibration wins, no conversion starts.
    wb_access(1'b1, 32'h0, 32'h6, rd);
    n_cmp++;
    if ({bus.adc_cal_o, bus.adc_en_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL cal_priority_pins got=%b expected=10", {bus.adc_cal_o, bus.adc_en_o});
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd1)) begin
      n_bad++;
      $display("FAIL cal_priority_state got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd1));
    end
    n = 0;
    while (bus.adc_cal_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0) || bus.adc_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL cal_priority_end got=%h en=%b expected=%h en=0", rd, bus.adc_en_o,
               exp_status(0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_single();
    wb_access(1'b1, 32'h0, 32'h4, rd);
    n_cmp++;
    if (bus.adc_en_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single_en_on got=%b expected=1", bus.adc_en_o);
    end
    adc_pulse(10'h2A5, 1'b1);
    n_cmp++;
    if (bus.adc_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL single_en_off got=%b expected=0", bus.adc_en_o);
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, 0, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL single_status got=%h expected=%h", rd, exp_status(m_cnt, 0, 0, 3'd0));
    end
    n_cmp++;
    if (bus.irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single_irq got=%b expected=1", bus.irq_o);
    end
    wb_access(1'b0, 32'h8, 32'h0, rd);
    exp = 32'h0;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      m_cnt--;
    end
    n_cmp++;
    if (rd !== exp) begin
      n_bad++;
      $display("FAIL single_data got=%h expected=%h", rd, exp);
    end
    wb_access(1'b0, 32'h8, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++;
      $display("FAIL single_data_empty got=%h expected=0", rd);
    end
    adc_pulse(10'h155, 1'b0);
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0) || bus.irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_edge_ignored got=%h irq=%b expected=%h irq=0", rd, bus.irq_o,
               exp_status(0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_run_overflow();
    wb_access(1'b1, 32'h0, 32'h1, rd);
    for (int i = 0; i < 9; i++) adc_pulse(RES_W'($urandom_range(0, 1023)), 1'b1);
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, m_ovf, 0, 3'd2)) begin
      n_bad++;
      $display("FAIL ovf_status got=%h expected=%h", rd, exp_status(m_cnt, m_ovf, 0, 3'd2));
    end
    n_cmp++;
    if (bus.irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_irq got=%b expected=1", bus.irq_o);
    end
    wb_access(1'b1, 32'h4, 32'h400, rd);
    m_ovf = 1'b0;
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, m_ovf, 0, 3'd2)) begin
      n_bad++;
      $display("FAIL ovf_w1c got=%h expected=%h", rd, exp_status(m_cnt, m_ovf, 0, 3'd2));
    end
  endtask

  task automatic test_back_to_back();
    logic [RES_W-1:0] r;
    r = RES_W'($urandom_range(0, 1023));
    // DATA read acknowledged on the same edge as a valid edge, FIFO full.
    @(negedge clk);
    bus.wbs_cyc_i    = 1'b1;
    bus.wbs_stb_i    = 1'b1;
    bus.wbs_we_i     = 1'b0;
    bus.wbs_sel_i    = 4'hF;
    bus.wbs_adr_i    = 32'h8;
    bus.adc_valid_i  = 1'b1;
    bus.adc_result_i = r;
    @(negedge clk);
    bus.adc_valid_i = 1'b0;
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pushpop_ack got=%b expected=1", bus.wbs_ack_o);
    end
    exp = exp_q.pop_front();
    exp_q.push_back({1'b1, 21'b0, r});
    n_cmp++;
    if (bus.wbs_dat_o !== exp) begin
      n_bad++;
      $display("FAIL pushpop_data got=%h expected=%h", bus.wbs_dat_o, exp);
    end
    bus_idle();
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, 0, 0, 3'd2)) begin
      n_bad++;
      $display("FAIL pushpop_status got=%h expected=%h", rd, exp_status(m_cnt, 0, 0, 3'd2));
    end
    wb_access(1'b1, 32'h0, 32'h0, rd);
    @(negedge clk);
    n_cmp++;
    if (bus.adc_en_o !== 1'b0) begin
      n_bad++;
      $display("FAIL run_clear_en got=%b expected=0", bus.adc_en_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      wb_access(1'b0, 32'h8, 32'h0, rd);
      exp = 32'h0;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        m_cnt--;
      end
      n_cmp++;
      if (rd !== exp) begin
        n_bad++;
        $display("FAIL drain_data[%0d] got=%h expected=%h", i, rd, exp);
      end
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL drain_status got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd0));
    end
  endtask

  task automatic test_timeout();
    int n;
    wb_access(1'b1, 32'h0, 32'h1, rd);
    n = 0;
    while (bus.adc_en_o === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != 1024) begin
      n_bad++;
      $display("FAIL timeout_length got=%0d expected=1024", n);
    end
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 1, 3'd0) || bus.irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_status got=%h irq=%b expected=%h irq=1", rd, bus.irq_o,
               exp_status(0, 0, 1, 3'd0));
    end
    wb_access(1'b1, 32'h4, 32'h800, rd);
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0) || bus.irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_w1c got=%h irq=%b expected=%h irq=0", rd, bus.irq_o,
               exp_status(0, 0, 0, 3'd0));
    end
    wb_access(1'b1, 32'h0, 32'h0, rd);
  endtask

  task automatic test_thresh_flush();
    wb_access(1'b1, 32'hC, 32'h4, rd);
    wb_access(1'b0, 32'hC, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h4) begin
      n_bad++;
      $display("FAIL thresh_readback got=%h expected=4", rd);
    end
    wb_access(1'b1, 32'h0, 32'h1, rd);
    for (int i = 0; i < 3; i++) adc_pulse(RES_W'($urandom_range(0, 1023)), 1'b1);
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, 0, 0, 3'd2) || bus.irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL thresh_below got=%h irq=%b expected=%h irq=0", rd, bus.irq_o,
               exp_status(m_cnt, 0, 0, 3'd2));
    end
    adc_pulse(RES_W'($urandom_range(0, 1023)), 1'b1);
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(m_cnt, 0, 0, 3'd2) || bus.irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL thresh_reached got=%h irq=%b expected=%h irq=1", rd, bus.irq_o,
               exp_status(m_cnt, 0, 0, 3'd2));
    end
    wb_access(1'b1, 32'hC, 32'h0, rd);
    wb_access(1'b0, 32'h0, 32'h0, rd);
    n_cmp++;
    if (bus.irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL thresh_zero_irq got=%b expected=0", bus.irq_o);
    end
    wb_access(1'b1, 32'h0, 32'h9, rd);
    exp_q.delete();
    m_cnt = 0;
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd2)) begin
      n_bad++;
      $display("FAIL flush_status got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd2));
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) adc_pulse(RES_W'($urandom_range(0, 1023)), 1'b1);
    n_cmp++;
    if (bus.adc_en_o !== 1'b1) begin
      n_bad++;
      $display("FAIL premid_en got=%b expected=1", bus.adc_en_o);
    end
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h4;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.wbs_ack_o, bus.adc_cal_o, bus.adc_en_o, bus.irq_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs got=%b expected=0000",
               {bus.wbs_ack_o, bus.adc_cal_o, bus.adc_en_o, bus.irq_o});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.wbs_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_ack got=%b expected=0", bus.wbs_ack_o);
    end
    bus_idle();
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    wb_access(1'b0, 32'h4, 32'h0, rd);
    n_cmp++;
    if (rd !== exp_status(0, 0, 0, 3'd0)) begin
      n_bad++;
      $display("FAIL midreset_status got=%h expected=%h", rd, exp_status(0, 0, 0, 3'd0));
    end
    wb_access(1'b0, 32'hC, 32'h0, rd);
    n_cmp++;
    if (rd !== 32'h1) begin
      n_bad++;
      $display("FAIL midreset_thresh got=%h expected=1", rd);
    end
  endtask

  initial begin
    bus_idle();
    bus.adc_valid_i  = 1'b0;
    bus.adc_result_i = '0;
    test_reset();
    test_cal();
    test_single();
    test_run_overflow();
    test_back_to_back();
    test_timeout();
    test_thresh_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
